flags_condition_unit: RTL and testbench
=======================================

FLAGS_CONDITION_UNIT -- requirements
Module: flags_condition_unit

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port alu_flags_czonENGL  input  8  active-low ALU flags: carry, zero, overflow, negative, equal, not-equal, greater, less (bit7..0).
REQ-004 SHALL have port _flag_di / _flag_do  input  1 each  active-low UART data-in-ready / data-out-ready.
REQ-005 SHALL have port _set_flags  input  1  active-low request to load flags this instruction.
REQ-006 SHALL have port condition  input  4  instruction condition code.
REQ-007 SHALL have ports phase_exec / _phase_exec  output  1 each  complementary phase indication.
REQ-008 SHALL have port status_czonENGL  output  8  registered active-low flags.
REQ-009 SHALL have port flags_valid  output  1  high once any flag load has occurred.
REQ-010 SHALL have port _do_exec  output  1  active-low registered "instruction executes".

Function
REQ-011 Phase register SHALL toggle every rising clk: fetch (phase_exec=0) -> exec (phase_exec=1) -> fetch.
REQ-012 On fetch->exec edge, _do_exec SHALL register NOT(cond_true); on exec->fetch edge it SHALL go 1; latency one edge, stable for entire exec phase.
REQ-013 cond_true (flags active-low, read from status_czonENGL, UART inputs live): 0 A always; 1 C; 2 Z; 3 O; 4 N; 5 EQ; 6 NE; 7 GT; 8 LT; 9 DI; 10 DO; 11 NC; 12 NZ; 13 GE = GT|EQ; 14 LE = LT|EQ; 15 NEVER.
REQ-014 Flags SHALL load only on the exec->fetch edge when _set_flags=0 AND _do_exec=0; never in fetch phase.
REQ-015 Skipped instruction (_do_exec=1) with _set_flags=0 SHALL leave status unchanged.
REQ-016 Conditional instruction following a flag load SHALL see the new flags (load precedes next fetch->exec sample).
REQ-017 _set_flags and condition SHALL be sampled only at their respective edges; mid-phase changes ignored.

Reset
REQ-018 reset SHALL asynchronously force phase_exec=0, _phase_exec=1, _do_exec=1, status_czonENGL=8'hFF, flags_valid=0 (plus shadow=8'hFF when compiled).
REQ-019 reset asserted mid-exec SHALL abort the pending flag load; first edge after release enters exec.

Configuration
REQ-020 Macro FLAGS_SHADOW_EN: when defined, adds inputs _save_flags, _restore_flags (active-low, sampled exec->fetch edge, gated by _do_exec=0) and an 8-bit shadow register.
REQ-021 With FLAGS_SHADOW_EN: save copies status to shadow; restore loads shadow into status with priority over _set_flags; simultaneous save+restore SHALL swap; restore sets flags_valid.
REQ-022 Without FLAGS_SHADOW_EN: ports and shadow absent; behaviour per REQ-011..019 only.

Structure
REQ-023 Condition code enum (16 names), flag bit index constants and a condname() function SHALL reside in shared package control.
REQ-024 Condition decode SHALL be one combinational sub-module condition_decoder; phase, flags and shadow registers reside in the top.

Verification
REQ-025 Reset then 2 clks -> phase_exec 0,1,0; _do_exec=1 in fetch; status=8'hFF; flags_valid=0.
REQ-026 alu_flags=8'h7F (carry), _set_flags=0, cond A -> after exec, status=8'h7F; next instr cond C -> _do_exec=0.
REQ-027 status=8'h7F, instr cond C with _set_flags=1, alu_flags=8'hFF -> status stays 8'h7F (preservation).
REQ-028 status=8'hFF, cond C with _set_flags=0, alu_flags=8'h00 -> _do_exec=1, status unchanged 8'hFF.
REQ-029 Change alu_flags and _set_flags=0 during fetch only -> no status change; bench flags any load not at exec->fetch edge.
REQ-030 FLAGS_SHADOW_EN: save 8'h7F, load 8'hBF, restore -> status=8'h7F; save+restore same edge -> status/shadow swapped.

Source files
------------

// File: rtl/flags_condition_unit_pkg.sv
// Shared control definitions: condition-code enum, active-low flag bit positions
// and a printable name helper for condition codes.
package control;

    typedef enum logic [3:0] {
        COND_A     = 4'd0,
        COND_C     = 4'd1,
        COND_Z     = 4'd2,
        COND_O     = 4'd3,
        COND_N     = 4'd4,
        COND_EQ    = 4'd5,
        COND_NE    = 4'd6,
        COND_GT    = 4'd7,
        COND_LT    = 4'd8,
        COND_DI    = 4'd9,
        COND_DO    = 4'd10,
        COND_NC    = 4'd11,
        COND_NZ    = 4'd12,
        COND_GE    = 4'd13,
        COND_LE    = 4'd14,
        COND_NEVER = 4'd15
    } cond_e;

    // Bit positions inside the active-low czonENGL flag vector
    localparam int unsigned FLAG_C  = 7;
    localparam int unsigned FLAG_Z  = 6;
    localparam int unsigned FLAG_O  = 5;
    localparam int unsigned FLAG_N  = 4;
    localparam int unsigned FLAG_EQ = 3;
    localparam int unsigned FLAG_NE = 2;
    localparam int unsigned FLAG_GT = 1;
    localparam int unsigned FLAG_LT = 0;

    function automatic logic [39:0] condname(input logic [3:0] code);
        logic [39:0] name;
        case (code)
            4'd0:    name = "A    ";
            4'd1:    name = "C    ";
            4'd2:    name = "Z    ";
            4'd3:    name = "O    ";
            4'd4:    name = "N    ";
            4'd5:    name = "EQ   ";
            4'd6:    name = "NE   ";
            4'd7:    name = "GT   ";
            4'd8:    name = "LT   ";
            4'd9:    name = "DI   ";
            4'd10:   name = "DO   ";
            4'd11:   name = "NC   ";
            4'd12:   name = "NZ   ";
            4'd13:   name = "GE   ";
            4'd14:   name = "LE   ";
            default: name = "NEVER";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/flags_condition_unit_if.sv
// Bus between the instruction sequencer and the flags/condition unit.
// FLAGS_SHADOW_EN adds the active-low save/restore strobes for the shadow register.
interface flags_condition_unit_if;

    logic [7:0] alu_flags_czonENGL;
    logic       _flag_di;
    logic       _flag_do;
    logic       _set_flags;
    logic [3:0] condition;
    logic       phase_exec;
    logic       _phase_exec;
    logic [7:0] status_czonENGL;
    logic       flags_valid;
    logic       _do_exec;

`ifdef FLAGS_SHADOW_EN
    logic       _save_flags;
    logic       _restore_flags;

    modport master (
        output alu_flags_czonENGL, _flag_di, _flag_do, _set_flags, condition,
               _save_flags, _restore_flags,
        input  phase_exec, _phase_exec, status_czonENGL, flags_valid, _do_exec
    );

    modport slave (
        input  alu_flags_czonENGL, _flag_di, _flag_do, _set_flags, condition,
               _save_flags, _restore_flags,
        output phase_exec, _phase_exec, status_czonENGL, flags_valid, _do_exec
    );
`else
    modport master (
        output alu_flags_czonENGL, _flag_di, _flag_do, _set_flags, condition,
        input  phase_exec, _phase_exec, status_czonENGL, flags_valid, _do_exec
    );

    modport slave (
        input  alu_flags_czonENGL, _flag_di, _flag_do, _set_flags, condition,
        output phase_exec, _phase_exec, status_czonENGL, flags_valid, _do_exec
    );
`endif

endinterface

// File: rtl/flags_condition_unit_decoder.sv
// Combinational condition evaluation against the registered active-low flags
// and the live active-low UART ready lines.
module condition_decoder
    import control::*;
(
    input  logic [3:0] condition,
    input  logic [7:0] status,
    input  logic       flag_di_n,
    input  logic       flag_do_n,
    output logic       cond_true
);

    // Flags are active-low, so "flag set" is the inverted bit
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(condition))
            COND_A:     cond_true = 1'b1;
            COND_C:     cond_true = ~status[FLAG_C];
            COND_Z:     cond_true = ~status[FLAG_Z];
            COND_O:     cond_true = ~status[FLAG_O];
            COND_N:     cond_true = ~status[FLAG_N];
            COND_EQ:    cond_true = ~status[FLAG_EQ];
            COND_NE:    cond_true = ~status[FLAG_NE];
            COND_GT:    cond_true = ~status[FLAG_GT];
            COND_LT:    cond_true = ~status[FLAG_LT];
            COND_DI:    cond_true = ~flag_di_n;
            COND_DO:    cond_true = ~flag_do_n;
            COND_NC:    cond_true = status[FLAG_C];
            COND_NZ:    cond_true = status[FLAG_Z];
            COND_GE:    cond_true = ~status[FLAG_GT] | ~status[FLAG_EQ];
            COND_LE:    cond_true = ~status[FLAG_LT] | ~status[FLAG_EQ];
            COND_NEVER: cond_true = 1'b0;
            default:    cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_condition_unit.sv
// Two-phase fetch/exec sequencer that registers the ALU flags and the
// "instruction executes" decision. Optional FLAGS_SHADOW_EN adds a save/restore shadow.
module flags_condition_unit
    import control::*;
(
    input  logic                   clk,
    input  logic                   reset,
    flags_condition_unit_if.slave  bus
);

    logic       phase_r;
    logic       phase_n_r;
    logic       do_exec_n_r;
    logic       valid_r;
    logic [7:0] status_r;
    logic [7:0] status_nxt_s;
    logic       load_s;
    logic       cond_true_s;
`ifdef FLAGS_SHADOW_EN
    logic [7:0] shadow_r;
    logic [7:0] shadow_nxt_s;
`endif

    condition_decoder u_decoder (
        .condition (bus.condition),
        .status    (status_r),
        .flag_di_n (bus._flag_di),
        .flag_do_n (bus._flag_do),
        .cond_true (cond_true_s)
    );

    // Next flag state: only an executing instruction at the end of exec may touch flags
    always_comb begin
        status_nxt_s = status_r;
        load_s       = 1'b0;
`ifdef FLAGS_SHADOW_EN
        shadow_nxt_s = shadow_r;
`endif
        if (phase_r && !do_exec_n_r) begin
`ifdef FLAGS_SHADOW_EN
            if (!bus._restore_flags) begin
                status_nxt_s = shadow_r;
                load_s       = 1'b1;
            end else if (!bus._set_flags) begin
                status_nxt_s = bus.alu_flags_czonENGL;
                load_s       = 1'b1;
            end else begin
                status_nxt_s = status_r;
                load_s       = 1'b0;
            end
            // Reads the old status, so save together with restore swaps the two
            if (!bus._save_flags) begin
                shadow_nxt_s = status_r;
            end else begin
                shadow_nxt_s = shadow_r;
            end
`else
            if (!bus._set_flags) begin
                status_nxt_s = bus.alu_flags_czonENGL;
                load_s       = 1'b1;
            end else begin
                status_nxt_s = status_r;
                load_s       = 1'b0;
            end
`endif
        end else begin
            status_nxt_s = status_r;
            load_s       = 1'b0;
        end
    end

    // Phase toggle, execute decision and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r     <= 1'b0;
            phase_n_r   <= 1'b1;
            do_exec_n_r <= 1'b1;
            valid_r     <= 1'b0;
            status_r    <= 8'hFF;
`ifdef FLAGS_SHADOW_EN
            shadow_r    <= 8'hFF;
`endif
        end else begin
            phase_r   <= ~phase_r;
            phase_n_r <= phase_r;
            if (!phase_r) begin
                do_exec_n_r <= ~cond_true_s;
            end else begin
                do_exec_n_r <= 1'b1;
            end
            status_r <= status_nxt_s;
            if (load_s) begin
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
`ifdef FLAGS_SHADOW_EN
            shadow_r <= shadow_nxt_s;
`endif
        end
    end

    assign bus.phase_exec      = phase_r;
    assign bus._phase_exec     = phase_n_r;
    assign bus._do_exec        = do_exec_n_r;
    assign bus.status_czonENGL = status_r;
    assign bus.flags_valid     = valid_r;

endmodule

// File: tb/tb_flags_condition_unit.sv
// Directed bench for flags_condition_unit: table of instructions with
// hand-computed results, plus reset/mid-phase/shadow sequences (FLAGS_SHADOW_EN).
module tb_flags_condition_unit;
    import control::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic mon_en;
    logic exp_valid;
    logic [7:0] prev_status;

    flags_condition_unit_if bus ();

    flags_condition_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] cond;
        logic       set_n;
        logic [7:0] alu;
        logic       di_n;
        logic       do_n;
        logic       exp_exec_n;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vec [24];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Status may only change on the edge that ends an exec phase
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.phase_exec === 1'b1 && bus.status_czonENGL !== prev_status) begin
                errors++;
                $display("FAIL load_outside_exec_end: got %h expected %h",
                         bus.status_czonENGL, prev_status);
            end
        end
        prev_status = bus.status_czonENGL;
    end

    // One full instruction starting at a fetch-phase negedge
    task automatic run_instr(input string name, input logic [3:0] c, input logic s,
                             input logic [7:0] a, input logic di, input logic dn,
                             input logic sv, input logic rs,
                             input logic exp_exec_n, input logic [7:0] exp_status);
        bus.condition          = c;
        bus._set_flags         = s;
        bus.alu_flags_czonENGL = a;
        bus._flag_di           = di;
        bus._flag_do           = dn;
`ifdef FLAGS_SHADOW_EN
        bus._save_flags        = sv;
        bus._restore_flags     = rs;
`endif
        @(negedge clk);
        check({name, "_phase_exec"}, {7'd0, bus.phase_exec}, 8'd1);
        check({name, "_nphase_exec"}, {7'd0, bus._phase_exec}, 8'd0);
        check({name, "_do_exec"}, {7'd0, bus._do_exec}, {7'd0, exp_exec_n});
        @(negedge clk);
        if (!exp_exec_n && (!s || !rs)) exp_valid = 1'b1;
        check({name, "_phase_fetch"}, {7'd0, bus.phase_exec}, 8'd0);
        check({name, "_do_exec_fetch"}, {7'd0, bus._do_exec}, 8'd1);
        check({name, "_status"}, bus.status_czonENGL, exp_status);
        check({name, "_valid"}, {7'd0, bus.flags_valid}, {7'd0, exp_valid});
        bus._set_flags = 1'b1;
`ifdef FLAGS_SHADOW_EN
        bus._save_flags    = 1'b1;
        bus._restore_flags = 1'b1;
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        exp_valid = 1'b0;
        reset     = 1'b1;
        bus.condition          = COND_NEVER;
        bus._set_flags         = 1'b1;
        bus.alu_flags_czonENGL = 8'hFF;
        bus._flag_di           = 1'b1;
        bus._flag_do           = 1'b1;
`ifdef FLAGS_SHADOW_EN
        bus._save_flags        = 1'b1;
        bus._restore_flags     = 1'b1;
`endif

        //            cond        set   alu    di    do    exec  status
        vec[0]  = {COND_A,     1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 8'h7F};
        vec[1]  = {COND_C,     1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h7F};
        vec[2]  = {COND_NC,    1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h7F};
        vec[3]  = {COND_Z,     1'b0, 8'hBF, 1'b1, 1'b1, 1'b1, 8'h7F};
        vec[4]  = {COND_NZ,    1'b0, 8'hBF, 1'b1, 1'b1, 1'b0, 8'hBF};
        vec[5]  = {COND_Z,     1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hBF};
        vec[6]  = {COND_NEVER, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hBF};
        vec[7]  = {COND_DI,    1'b0, 8'hF7, 1'b0, 1'b1, 1'b0, 8'hF7};
        vec[8]  = {COND_DI,    1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hF7};
        vec[9]  = {COND_GE,    1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hF7};
        vec[10] = {COND_LE,    1'b0, 8'hFE, 1'b1, 1'b1, 1'b0, 8'hFE};
        vec[11] = {COND_GT,    1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFE};
        vec[12] = {COND_LT,    1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFE};
        vec[13] = {COND_DO,    1'b0, 8'hFD, 1'b1, 1'b0, 1'b0, 8'hFD};
        vec[14] = {COND_GE,    1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFD};
        vec[15] = {COND_EQ,    1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFD};
        vec[16] = {COND_NE,    1'b0, 8'hFB, 1'b1, 1'b1, 1'b1, 8'hFD};
        vec[17] = {COND_O,     1'b0, 8'hDF, 1'b1, 1'b1, 1'b1, 8'hFD};
        vec[18] = {COND_N,     1'b0, 8'hEF, 1'b1, 1'b1, 1'b1, 8'hFD};
        vec[19] = {COND_A,     1'b0, 8'hEF, 1'b1, 1'b1, 1'b0, 8'hEF};
        vec[20] = {COND_N,     1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vec[21] = {COND_O,     1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vec[22] = {COND_A,     1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        vec[23] = {COND_C,     1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF};

        // Reset values before any clock edge
        #2;
        check("rst_phase_exec", {7'd0, bus.phase_exec}, 8'd0);
        check("rst_nphase_exec", {7'd0, bus._phase_exec}, 8'd1);
        check("rst_do_exec", {7'd0, bus._do_exec}, 8'd1);
        check("rst_status", bus.status_czonENGL, 8'hFF);
        check("rst_valid", {7'd0, bus.flags_valid}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("clk1_phase_exec", {7'd0, bus.phase_exec}, 8'd1);
        check("clk1_do_exec", {7'd0, bus._do_exec}, 8'd1);
        @(negedge clk);
        check("clk2_phase_exec", {7'd0, bus.phase_exec}, 8'd0);
        check("clk2_status", bus.status_czonENGL, 8'hFF);
        check("clk2_valid", {7'd0, bus.flags_valid}, 8'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 24; i++) begin
            run_instr($sformatf("row%0d_%s", i, condname(vec[i].cond)),
                      vec[i].cond, vec[i].set_n, vec[i].alu, vec[i].di_n, vec[i].do_n,
                      1'b1, 1'b1, vec[i].exp_exec_n, vec[i].exp_status);
        end

        // Load request and condition change only around fetch->exec: ignored
        bus.condition          = COND_A;
        bus._set_flags         = 1'b0;
        bus.alu_flags_czonENGL = 8'h00;
        @(posedge clk);
        #1;
        bus.condition          = COND_NEVER;
        bus._set_flags         = 1'b1;
        bus.alu_flags_czonENGL = 8'hFF;
        @(negedge clk);
        check("midphase_do_exec", {7'd0, bus._do_exec}, 8'd0);
        @(negedge clk);
        check("midphase_status", bus.status_czonENGL, 8'hFF);

        // Reset in exec aborts the pending load of 8'h00
        bus.condition          = COND_A;
        bus._set_flags         = 1'b0;
        bus.alu_flags_czonENGL = 8'h00;
        @(negedge clk);
        check("abort_do_exec", {7'd0, bus._do_exec}, 8'd0);
        #1 reset = 1'b1;
        #1;
        check("abort_phase_exec", {7'd0, bus.phase_exec}, 8'd0);
        check("abort_nphase_exec", {7'd0, bus._phase_exec}, 8'd1);
        check("abort_rst_do_exec", {7'd0, bus._do_exec}, 8'd1);
        check("abort_rst_status", bus.status_czonENGL, 8'hFF);
        check("abort_rst_valid", {7'd0, bus.flags_valid}, 8'd0);
        #1 reset = 1'b0;
        exp_valid      = 1'b0;
        bus._set_flags = 1'b1;
        @(negedge clk);
        check("after_rst_phase_exec", {7'd0, bus.phase_exec}, 8'd1);
        check("after_rst_status", bus.status_czonENGL, 8'hFF);
        @(negedge clk);
        check("after_rst_phase_fetch", {7'd0, bus.phase_exec}, 8'd0);
        check("after_rst_status2", bus.status_czonENGL, 8'hFF);
        check("after_rst_valid", {7'd0, bus.flags_valid}, 8'd0);

`ifdef FLAGS_SHADOW_EN
        run_instr("sh_load7F",   COND_A,     1'b0, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7F);
        run_instr("sh_save",     COND_A,     1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F);
        run_instr("sh_loadBF",   COND_A,     1'b0, 8'hBF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hBF);
        run_instr("sh_restore",  COND_A,     1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F);
        run_instr("sh_loadBF2",  COND_A,     1'b0, 8'hBF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hBF);
        run_instr("sh_swap",     COND_A,     1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
        run_instr("sh_skip_rst", COND_NEVER, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F);
        run_instr("sh_prio",     COND_A,     1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hBF);
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
